// File: rtl/vga_sync_gen_if.sv
// Video timing bundle between the raster generator and its consumers.
// The consumer side owns the sync polarity select; everything else flows downstream.
interface vga_sync_gen_if;
    logic       polarity;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  polarity,
        output hsync, vsync, visible, pix_x, pix_y,
        output line_start, frame_start, frame_count
    );

    modport slave (
        output polarity,
        input  hsync, vsync, visible, pix_x, pix_y,
        input  line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running raster timing generator: 11-bit h/v counters, registered sync/active flags,
// pixel coordinates, line/frame strobes and a wrapping completed-frame counter.
module vga_sync_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_sync_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync end bounds stay below the total because the back porch is at least one unit,
    // so every bound fits in 11 bits even when a total reaches 2048.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] H_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_count_reg, h_count_next;
    logic [10:0] v_count_reg, v_count_next;
    logic [7:0]  frame_count_reg, frame_count_next;
    logic        h_wrap, v_wrap;
    logic        h_act, v_act, hs_i, vs_i;

    logic        visible_reg;
    logic [9:0]  pix_x_reg, pix_y_reg;
    logic        line_start_reg, frame_start_reg;
    logic        hs_reg, vs_reg;

    always_comb begin
        h_wrap           = (h_count_reg == H_LAST);
        v_wrap           = (v_count_reg == V_LAST);
        h_count_next     = h_wrap ? 11'd0 : h_count_reg + 11'd1;
        v_count_next     = v_count_reg;
        frame_count_next = frame_count_reg;
        if (h_wrap) begin
            v_count_next = v_wrap ? 11'd0 : v_count_reg + 11'd1;
            if (v_wrap) begin
                frame_count_next = frame_count_reg + 8'd1;
            end
        end
    end

    // vs_i depends only on v_count, so it moves on line boundaries by construction.
    always_comb begin
        h_act = (h_count_reg < H_ACT_END);
        v_act = (v_count_reg < V_ACT_END);
        hs_i  = (h_count_reg >= H_HS_START) && (h_count_reg < H_HS_END);
        vs_i  = (v_count_reg >= V_VS_START) && (v_count_reg < V_VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count_reg     <= '0;
            v_count_reg     <= '0;
            frame_count_reg <= '0;
            visible_reg     <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            hs_reg          <= 1'b0;
            vs_reg          <= 1'b0;
        end else begin
            h_count_reg     <= h_count_next;
            v_count_reg     <= v_count_next;
            frame_count_reg <= frame_count_next;
            visible_reg     <= h_act & v_act;
            pix_x_reg       <= h_act ? h_count_reg[9:0] : 10'd0;
            pix_y_reg       <= v_act ? v_count_reg[9:0] : 10'd0;
            line_start_reg  <= (h_count_reg == 11'd0);
            frame_start_reg <= (h_count_reg == 11'd0) && (v_count_reg == 11'd0);
            hs_reg          <= hs_i;
            vs_reg          <= vs_i;
        end
    end

    // Polarity is applied after the register so a change is visible without waiting a clock.
    assign vid.hsync       = hs_reg ^ ~vid.polarity;
    assign vid.vsync       = vs_reg ^ ~vid.polarity;
    assign vid.visible     = visible_reg;
    assign vid.pix_x       = pix_x_reg;
    assign vid.pix_y       = pix_y_reg;
    assign vid.line_start  = line_start_reg;
    assign vid.frame_start = frame_start_reg;
    assign vid.frame_count = frame_count_reg;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: small 14x7 raster instance for detailed timing, default XGA instance for line timing.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k = 0;

    vga_sync_gen_if sim_if ();
    vga_sync_gen_if xga_if ();

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (sim_if)
    );

    vga_sync_gen xga_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (xga_if)
    );

    always #5 clk = ~clk;

    initial begin
        sim_if.polarity = 1'b1;
        xga_if.polarity = 1'b1;
    end

    function automatic int hp(input int c);
        return c % 14;
    endfunction

    function automatic int vp(input int c);
        return (c / 14) % 7;
    endfunction

    // Release on a falling edge; sample k=0 then sits on the following falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sim_if.polarity = 1'b1;
        #1;
        n_cmp++; if (sim_if.visible !== 1'b0) begin n_bad++; $display("FAIL reset_visible got=%b exp=0", sim_if.visible); end
        n_cmp++; if (sim_if.pix_x !== 10'd0 || sim_if.pix_y !== 10'd0) begin n_bad++; $display("FAIL reset_pix got=(%0d,%0d) exp=(0,0)", sim_if.pix_x, sim_if.pix_y); end
        n_cmp++; if (sim_if.line_start !== 1'b0 || sim_if.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_strobes got=%b%b exp=00", sim_if.line_start, sim_if.frame_start); end
        n_cmp++; if (sim_if.frame_count !== 8'd0) begin n_bad++; $display("FAIL reset_fcount got=%0d exp=0", sim_if.frame_count); end
        n_cmp++; if (sim_if.hsync !== 1'b0 || sim_if.vsync !== 1'b0) begin n_bad++; $display("FAIL reset_sync_pol1 got=%b%b exp=00", sim_if.hsync, sim_if.vsync); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (sim_if.visible !== 1'b0 || sim_if.line_start !== 1'b0) begin n_bad++; $display("FAIL reset_hold got=%b%b exp=00", sim_if.visible, sim_if.line_start); end
        sim_if.polarity = 1'b0;
        #1;
        n_cmp++; if (sim_if.hsync !== 1'b1 || sim_if.vsync !== 1'b1) begin n_bad++; $display("FAIL reset_sync_pol0 got=%b%b exp=11", sim_if.hsync, sim_if.vsync); end
        sim_if.polarity = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_line();
        sim_if.polarity = 1'b1;
        do_reset();
        repeat (28) begin
            @(negedge clk);
            n_cmp++; if (sim_if.visible !== (hp(k) < 8 && vp(k) < 4)) begin n_bad++; $display("FAIL line_visible k=%0d got=%b", k, sim_if.visible); end
            n_cmp++; if (sim_if.pix_x !== 10'((hp(k) < 8) ? hp(k) : 0)) begin n_bad++; $display("FAIL line_pix_x k=%0d got=%0d", k, sim_if.pix_x); end
            n_cmp++; if (sim_if.pix_y !== 10'(vp(k))) begin n_bad++; $display("FAIL line_pix_y k=%0d got=%0d exp=%0d", k, sim_if.pix_y, vp(k)); end
            n_cmp++; if (sim_if.line_start !== (hp(k) == 0)) begin n_bad++; $display("FAIL line_start k=%0d got=%b", k, sim_if.line_start); end
            n_cmp++; if (sim_if.frame_start !== (k == 0)) begin n_bad++; $display("FAIL line_frame_start k=%0d got=%b", k, sim_if.frame_start); end
            k++;
        end
        $display("test_line done");
    endtask

    task automatic test_hsync();
        int highs;
        sim_if.polarity = 1'b1;
        do_reset();
        highs = 0;
        repeat (98) begin
            @(negedge clk);
            if (sim_if.hsync === 1'b1) highs++;
            n_cmp++; if (sim_if.hsync !== (hp(k) == 10 || hp(k) == 11)) begin n_bad++; $display("FAIL hsync_pol1 k=%0d h=%0d got=%b", k, hp(k), sim_if.hsync); end
            k++;
        end
        n_cmp++; if (highs !== 14) begin n_bad++; $display("FAIL hsync_width got=%0d exp=14", highs); end
        sim_if.polarity = 1'b0;
        #1;
        n_cmp++; if (sim_if.hsync !== 1'b1) begin n_bad++; $display("FAIL hsync_pol_switch got=%b exp=1", sim_if.hsync); end
        repeat (98) begin
            @(negedge clk);
            n_cmp++; if (sim_if.hsync !== !(hp(k) == 10 || hp(k) == 11)) begin n_bad++; $display("FAIL hsync_pol0 k=%0d h=%0d got=%b", k, hp(k), sim_if.hsync); end
            n_cmp++; if (sim_if.vsync !== !(vp(k) == 5)) begin n_bad++; $display("FAIL vsync_pol0 k=%0d v=%0d got=%b", k, vp(k), sim_if.vsync); end
            k++;
        end
        sim_if.polarity = 1'b1;
        $display("test_hsync done");
    endtask

    task automatic test_vsync();
        int highs;
        highs = 0;
        repeat (98) begin
            @(negedge clk);
            if (sim_if.vsync === 1'b1) highs++;
            n_cmp++; if (sim_if.vsync !== (vp(k) == 5)) begin n_bad++; $display("FAIL vsync k=%0d v=%0d got=%b", k, vp(k), sim_if.vsync); end
            if (vp(k) >= 4) begin
                n_cmp++; if (sim_if.visible !== 1'b0 || sim_if.pix_y !== 10'd0) begin n_bad++; $display("FAIL vblank k=%0d got vis=%b y=%0d exp 0/0", k, sim_if.visible, sim_if.pix_y); end
            end
            k++;
        end
        n_cmp++; if (highs !== 14) begin n_bad++; $display("FAIL vsync_width got=%0d exp=14", highs); end
        $display("test_vsync done");
    endtask

    task automatic test_frames();
        sim_if.polarity = 1'b1;
        do_reset();
        repeat (256 * 98 + 2) begin
            @(negedge clk);
            n_cmp++; if (sim_if.frame_start !== (k % 98 == 0)) begin n_bad++; $display("FAIL frame_start k=%0d got=%b", k, sim_if.frame_start); end
            n_cmp++; if (sim_if.frame_count !== 8'(((k + 1) / 98) % 256)) begin n_bad++; $display("FAIL frame_count k=%0d got=%0d exp=%0d", k, sim_if.frame_count, ((k + 1) / 98) % 256); end
            k++;
        end
        $display("test_frames done");
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2 * 98 + 2 * 14 + 5 + 1) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (sim_if.pix_x !== 10'd5 || sim_if.pix_y !== 10'd2 || sim_if.frame_count !== 8'd2) begin n_bad++; $display("FAIL pre_reset_pos got=(%0d,%0d) fc=%0d exp=(5,2) fc=2", sim_if.pix_x, sim_if.pix_y, sim_if.frame_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sim_if.visible !== 1'b0 || sim_if.pix_x !== 10'd0 || sim_if.pix_y !== 10'd0) begin n_bad++; $display("FAIL async_rst_pix got vis=%b (%0d,%0d)", sim_if.visible, sim_if.pix_x, sim_if.pix_y); end
        n_cmp++; if (sim_if.frame_count !== 8'd0 || sim_if.hsync !== 1'b0 || sim_if.vsync !== 1'b0) begin n_bad++; $display("FAIL async_rst_misc got fc=%0d hs=%b vs=%b", sim_if.frame_count, sim_if.hsync, sim_if.vsync); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sim_if.visible !== 1'b0 || sim_if.line_start !== 1'b0) begin n_bad++; $display("FAIL async_rst_hold got vis=%b ls=%b", sim_if.visible, sim_if.line_start); end
        rst_n = 1'b1;
        k = 0;
        repeat (14) begin
            @(negedge clk);
            n_cmp++; if (sim_if.pix_x !== 10'((k < 8) ? k : 0) || sim_if.pix_y !== 10'd0) begin n_bad++; $display("FAIL restart_pix k=%0d got=(%0d,%0d)", k, sim_if.pix_x, sim_if.pix_y); end
            n_cmp++; if (sim_if.frame_start !== (k == 0) || sim_if.frame_count !== 8'd0) begin n_bad++; $display("FAIL restart_frame k=%0d got fs=%b fc=%0d", k, sim_if.frame_start, sim_if.frame_count); end
            k++;
        end
        $display("test_async_reset done");
    endtask

    task automatic test_xga();
        int ls_k[$];
        int hs_cnt;
        int hs_first;
        int max_x;
        int fs_cnt;
        hs_cnt = 0; hs_first = -1; max_x = 0; fs_cnt = 0;
        xga_if.polarity = 1'b1;
        do_reset();
        repeat (3 * 1344 + 10) begin
            @(negedge clk);
            if (xga_if.line_start === 1'b1) ls_k.push_back(k);
            if (xga_if.frame_start === 1'b1) fs_cnt++;
            if (k < 1344 && xga_if.hsync === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (int'(xga_if.pix_x) > max_x) max_x = int'(xga_if.pix_x);
            if (k == 1023) begin
                n_cmp++; if (xga_if.visible !== 1'b1 || xga_if.pix_x !== 10'd1023) begin n_bad++; $display("FAIL xga_last_pixel got vis=%b x=%0d", xga_if.visible, xga_if.pix_x); end
            end
            if (k == 1024) begin
                n_cmp++; if (xga_if.visible !== 1'b0 || xga_if.pix_x !== 10'd0) begin n_bad++; $display("FAIL xga_hblank got vis=%b x=%0d", xga_if.visible, xga_if.pix_x); end
            end
            if (k == 1344) begin
                n_cmp++; if (xga_if.pix_y !== 10'd1 || xga_if.pix_x !== 10'd0) begin n_bad++; $display("FAIL xga_line1 got=(%0d,%0d) exp=(0,1)", xga_if.pix_x, xga_if.pix_y); end
            end
            k++;
        end
        n_cmp++; if (ls_k.size() !== 4) begin n_bad++; $display("FAIL xga_line_count got=%0d exp=4", ls_k.size()); end
        else begin
            n_cmp++; if (ls_k[1] - ls_k[0] !== 1344 || ls_k[3] - ls_k[2] !== 1344) begin n_bad++; $display("FAIL xga_line_period got=%0d,%0d exp=1344", ls_k[1] - ls_k[0], ls_k[3] - ls_k[2]); end
        end
        n_cmp++; if (hs_cnt !== 136) begin n_bad++; $display("FAIL xga_hsync_width got=%0d exp=136", hs_cnt); end
        n_cmp++; if (hs_first !== 1048) begin n_bad++; $display("FAIL xga_hsync_start got=%0d exp=1048", hs_first); end
        n_cmp++; if (max_x !== 1023) begin n_bad++; $display("FAIL xga_max_pix_x got=%0d exp=1023", max_x); end
        n_cmp++; if (fs_cnt !== 1) begin n_bad++; $display("FAIL xga_frame_start got=%0d exp=1", fs_cnt); end
        $display("test_xga done");
    endtask

    initial begin
        test_reset();
        test_line();
        test_hsync();
        test_vsync();
        test_frames();
        test_async_reset();
        test_xga();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
